seq_divider: RTL

- Iterative multi-cycle integer divider consumed by the CPU's ALU command when alu_op[5] is set.
- CPU pulses go for one cycle with operands on a/b, then polls available each cycle and writes c, is_zero and is_negative into the destination register and flags.
- Restoring algorithm, one quotient bit per cycle, signed or unsigned, quotient or remainder output.

---
 rtl/robin_div_pkg.sv | 20 ++
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/robin_div_pkg.sv
// Shared types and constants for the seq_divider restoring divider.
// Build option SEQ_DIVIDER_EARLY_EXIT_EN (see seq_divider.sv) does not affect this package.
package robin_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    // Widest operand the all-ones constant covers; narrower instances slice it.
    localparam int DIV_MAX_W = 64;
    localparam logic [DIV_MAX_W-1:0] DIV_QUOT_ALL_ONES = {DIV_MAX_W{1'b1}};

    function automatic int div_cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module div_step #(
    parameter int width = 32
) (
    input  logic [width:0]   pr,
    input  logic [width-1:0] mb,
    input  logic             bit_in,
    output logic [width:0]   pr_next,
    output logic             q_bit
);

    logic [width+1:0] shifted_s;
    logic [width+1:0] diff_s;

    // pr < mb always holds, so the shifted value fits width+1 bits and the
    // sign of the width+2-bit difference is the restore decision.
    always_comb begin
        shifted_s = {pr, bit_in};
        diff_s    = shifted_s - {2'b00, mb};
        q_bit     = ~diff_s[width+1];
        if (q_bit) begin
            pr_next = diff_s[width:0];
        end else begin
            pr_next = shifted_s[width:0];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle, signed/unsigned.
// Define SEQ_DIVIDER_EARLY_EXIT_EN to bypass BUSY when the divisor is zero or exceeds the dividend.
module seq_divider
    import robin_div_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             go,
    input  logic             divs,
    input  logic             remainder,
    output logic [width-1:0] c,
    output logic             is_zero,
    output logic             is_negative,
    output logic             available
);

    localparam int DIV_CNT_W = div_cnt_w(width);
    localparam logic [width-1:0] QUOT_ONES = DIV_QUOT_ALL_ONES[width-1:0];

    function automatic logic [width-1:0] twos_neg(input logic [width-1:0] x);
        return ~x + {{(width-1){1'b0}}, 1'b1};
    endfunction

    div_state_e           state_r, state_nxt_s;
    logic [width-1:0]     dvd_r, dvd_nxt_s;
    logic [width:0]       pr_r, pr_nxt_s;
    logic [width-1:0]     mb_r, mb_nxt_s;
    logic [DIV_CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic                 sq_r, sq_nxt_s;
    logic                 sr_r, sr_nxt_s;
    logic                 rem_sel_r, rem_sel_nxt_s;
    logic                 dz_r, dz_nxt_s;
    logic                 done_r, done_nxt_s;
    logic [width-1:0]     c_r, c_nxt_s;
    logic                 is_zero_r, is_zero_nxt_s;
    logic                 is_neg_r, is_neg_nxt_s;

    logic [width-1:0]     ma_s, mb_s;
    logic [width:0]       step_pr_s;
    logic                 step_q_s;
    logic [width-1:0]     quot_s, rem_s, res_s;

    // dvd_r shifts the dividend out of its MSB while quotient bits enter its LSB.
    div_step #(.width(width)) u_step (
        .pr      (pr_r),
        .mb      (mb_r),
        .bit_in  (dvd_r[width-1]),
        .pr_next (step_pr_s),
        .q_bit   (step_q_s)
    );

    // Operand magnitudes and the sign-corrected results presented in FIXUP.
    always_comb begin
        ma_s = (divs & a[width-1]) ? twos_neg(a) : a;
        mb_s = (divs & b[width-1]) ? twos_neg(b) : b;
        if (dz_r) begin
            quot_s = QUOT_ONES;
        end else if (sq_r) begin
            quot_s = twos_neg(dvd_r);
        end else begin
            quot_s = dvd_r;
        end
        // Negating |a| restores a exactly, which covers the divide-by-zero remainder.
        if (sr_r) begin
            rem_s = twos_neg(pr_r[width-1:0]);
        end else begin
            rem_s = pr_r[width-1:0];
        end
        if (rem_sel_r) begin
            res_s = rem_s;
        end else begin
            res_s = quot_s;
        end
    end

    // Next-state and datapath update; a go pulse restarts from any state.
    always_comb begin
        state_nxt_s   = state_r;
        dvd_nxt_s     = dvd_r;
        pr_nxt_s      = pr_r;
        mb_nxt_s      = mb_r;
        cnt_nxt_s     = cnt_r;
        sq_nxt_s      = sq_r;
        sr_nxt_s      = sr_r;
        rem_sel_nxt_s = rem_sel_r;
        dz_nxt_s      = dz_r;
        done_nxt_s    = done_r;
        c_nxt_s       = c_r;
        is_zero_nxt_s = is_zero_r;
        is_neg_nxt_s  = is_neg_r;
        if (go) begin
            sq_nxt_s      = divs & (a[width-1] ^ b[width-1]);
            sr_nxt_s      = divs & a[width-1];
            rem_sel_nxt_s = remainder;
            dz_nxt_s      = (mb_s == {width{1'b0}});
            mb_nxt_s      = mb_s;
            cnt_nxt_s     = DIV_CNT_W'(width - 1);
            done_nxt_s    = 1'b0;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
            if ((mb_s == {width{1'b0}}) || (mb_s > ma_s)) begin
                state_nxt_s = FIXUP;
                dvd_nxt_s   = {width{1'b0}};
                pr_nxt_s    = {1'b0, ma_s};
            end else begin
                state_nxt_s = BUSY;
                dvd_nxt_s   = ma_s;
                pr_nxt_s    = {(width+1){1'b0}};
            end
`else
            state_nxt_s = BUSY;
            dvd_nxt_s   = ma_s;
            pr_nxt_s    = {(width+1){1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                BUSY: begin
                    dvd_nxt_s = {dvd_r[width-2:0], step_q_s};
                    pr_nxt_s  = step_pr_s;
                    if (cnt_r == {DIV_CNT_W{1'b0}}) begin
                        state_nxt_s = FIXUP;
                    end else begin
                        cnt_nxt_s = cnt_r - DIV_CNT_W'(1);
                    end
                end
                FIXUP: begin
                    c_nxt_s       = res_s;
                    is_zero_nxt_s = (res_s == {width{1'b0}});
                    is_neg_nxt_s  = res_s[width-1];
                    done_nxt_s    = 1'b1;
                    state_nxt_s   = DONE;
                end
                DONE: begin
                    state_nxt_s = DONE;
                end
                default: begin
                    state_nxt_s = IDLE;
                    done_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            dvd_r     <= {width{1'b0}};
            pr_r      <= {(width+1){1'b0}};
            mb_r      <= {width{1'b0}};
            cnt_r     <= {DIV_CNT_W{1'b0}};
            sq_r      <= 1'b0;
            sr_r      <= 1'b0;
            rem_sel_r <= 1'b0;
            dz_r      <= 1'b0;
            done_r    <= 1'b0;
            c_r       <= {width{1'b0}};
            is_zero_r <= 1'b0;
            is_neg_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            dvd_r     <= dvd_nxt_s;
            pr_r      <= pr_nxt_s;
            mb_r      <= mb_nxt_s;
            cnt_r     <= cnt_nxt_s;
            sq_r      <= sq_nxt_s;
            sr_r      <= sr_nxt_s;
            rem_sel_r <= rem_sel_nxt_s;
            dz_r      <= dz_nxt_s;
            done_r    <= done_nxt_s;
            c_r       <= c_nxt_s;
            is_zero_r <= is_zero_nxt_s;
            is_neg_r  <= is_neg_nxt_s;
        end
    end

    assign c           = c_r;
    assign is_zero     = is_zero_r;
    assign is_negative = is_neg_r;
    // Masked by go so a stale result is never seen in the cycle a new one starts.
    assign available   = done_r & ~go;

endmodule
